// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - IF-stage PC register with branch/jump/exception redirect and pending-hold engine
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       PCSource,
    input  logic [31:0]      PC_branch,
    input  logic [31:0]      PC_jump,
    input  logic             Stall,
    input  logic             imem_ready,
    output logic [31:0]      PC,
    output logic [31:0]      PC_plus4,
    output logic             Flush_IF,
    output logic             Flush_ID,
    output logic             Flush_EX,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [1:0] SRC_SEQ    = 2'd0;
    localparam logic [1:0] SRC_BRANCH = 2'd1;
    localparam logic [1:0] SRC_JUMP   = 2'd2;
    localparam logic [1:0] SRC_EXC    = 2'd3;

    // Low two bits are dropped everywhere a target is loaded so PC stays word-aligned.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] EXC_TGT    = EXC_VECTOR & ALIGN_MASK;
    localparam logic [31:0] RST_TGT    = RESET_PC & ALIGN_MASK;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q,    state_d;
    logic [31:0]      pc_q,       pc_d;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    logic             pend_exc_q, pend_exc_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic [31:0] tgt_raw;
    logic [31:0] tgt;
    logic        redirect_req;
    logic        redirect_apply;
    logic        flush_all;

    // Select the redirect target from the MEM-stage source and force word alignment.
    always_comb begin
        tgt_raw = EXC_VECTOR;
        case (PCSource)
            SRC_BRANCH: tgt_raw = PC_branch;
            SRC_JUMP:   tgt_raw = PC_jump;
            default:    tgt_raw = EXC_VECTOR;
        endcase
        tgt = tgt_raw & ALIGN_MASK;
    end

    assign redirect_req = (PCSource != SRC_SEQ);

    // Next-state logic: sequential advance, immediate redirect, or park the redirect in HOLD.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_tgt_d     = pend_tgt_q;
        pend_exc_d     = pend_exc_q;
        redirect_apply = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!redirect_req) begin
                    if (!Stall && imem_ready) begin
                        pc_d = PC_plus4;
                    end
                end else if (imem_ready) begin
                    // Younger instructions are squashed, so Stall has no say here.
                    pc_d           = tgt;
                    redirect_apply = 1'b1;
                end else begin
                    pend_tgt_d = tgt;
                    pend_exc_d = (PCSource == SRC_EXC);
                    state_d    = ST_HOLD;
                end
            end
            default: begin
                // Branch/jump requests seen here come from squashed slots; only an
                // exception may replace the parked target.
                if (PCSource == SRC_EXC) begin
                    pend_tgt_d = EXC_TGT;
                    pend_exc_d = 1'b1;
                end
                if (imem_ready) begin
                    pc_d           = ((PCSource == SRC_EXC) || pend_exc_q) ? EXC_TGT : pend_tgt_q;
                    state_d        = ST_RUN;
                    pend_exc_d     = 1'b0;
                    redirect_apply = 1'b1;
                end
            end
        endcase
    end

    // Redirect counter saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (redirect_apply && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset discards any pending redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RST_TGT;
            pend_tgt_q <= 32'd0;
            pend_exc_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_exc_q <= pend_exc_d;
            cnt_q      <= cnt_d;
        end
    end

    // Flushes follow a redirect request combinationally and stay high for the whole HOLD.
    always_comb begin
        flush_all = rst_n && (redirect_req || (state_q == ST_HOLD));
    end

    assign PC               = pc_q;
    assign PC_plus4         = pc_q + 32'd4;
    assign Flush_IF         = flush_all;
    assign Flush_ID         = flush_all;
    assign Flush_EX         = flush_all;
    assign redirect_pending = rst_n && (state_q == ST_HOLD);
    assign redirect_cnt     = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - scoreboard bench for pc_redirect_unit
module tb_pc_redirect_unit;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic [1:0]    PCSource;
    logic [31:0]   PC_branch;
    logic [31:0]   PC_jump;
    logic          Stall;
    logic          imem_ready;
    logic [31:0]   PC;
    logic [31:0]   PC_plus4;
    logic          Flush_IF;
    logic          Flush_ID;
    logic          Flush_EX;
    logic          redirect_pending;
    logic [CW-1:0] redirect_cnt;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   pc4;
        logic [CW-1:0] cnt;
        logic          fl;
        logic          pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pc_redirect_unit #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0180),
        .CNT_W      (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PCSource         (PCSource),
        .PC_branch        (PC_branch),
        .PC_jump          (PC_jump),
        .Stall            (Stall),
        .imem_ready       (imem_ready),
        .PC               (PC),
        .PC_plus4         (PC_plus4),
        .Flush_IF         (Flush_IF),
        .Flush_ID         (Flush_ID),
        .Flush_EX         (Flush_EX),
        .redirect_pending (redirect_pending),
        .redirect_cnt     (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Monitor: outputs are sampled mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check32("pc", PC, e.pc);
            check32("pc_plus4", PC_plus4, e.pc4);
            check32("flush", {29'd0, Flush_IF, Flush_ID, Flush_EX}, {29'd0, {3{e.fl}}});
            check32("pending", {31'd0, redirect_pending}, {31'd0, e.pend});
            check32("cnt", {{(32-CW){1'b0}}, redirect_cnt}, {{(32-CW){1'b0}}, e.cnt});
        end
    end

    task automatic step(input logic r, input logic [1:0] s, input logic [31:0] br,
                        input logic [31:0] jp, input logic st, input logic rdy,
                        input logic [31:0] epc, input logic [CW-1:0] ecnt,
                        input logic efl, input logic epend);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n      = r;
        PCSource   = s;
        PC_branch  = br;
        PC_jump    = jp;
        Stall      = st;
        imem_ready = rdy;
        e.pc   = epc;
        e.pc4  = epc + 32'd4;
        e.cnt  = ecnt;
        e.fl   = efl;
        e.pend = epend;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; PCSource = 2'd0; PC_branch = 32'd0; PC_jump = 32'd0;
        Stall = 1'b0; imem_ready = 1'b1;
        //     rst  src  branch        jump          stl rdy  exp_pc        cnt fl pend
        // reset and sequential fetch
        step(1'b0, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0000, 0, 0, 0);
        step(1'b0, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0000, 0, 0, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0000, 0, 0, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0004, 0, 0, 0);
        // stall at PC=8
        step(1'b1, 2'd0, 32'h0,        32'h0,        1, 1, 32'h0000_0008, 0, 0, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        1, 1, 32'h0000_0008, 0, 0, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        1, 1, 32'h0000_0008, 0, 0, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0008, 0, 0, 0);
        // branch taken while stalled
        step(1'b1, 2'd1, 32'h40,       32'h0,        1, 1, 32'h0000_000C, 0, 1, 0);
        // jump parked while imem not ready
        step(1'b1, 2'd2, 32'h0,        32'h100,      0, 0, 32'h0000_0040, 1, 1, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0000_0040, 1, 1, 1);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0040, 1, 1, 1);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0100, 2, 0, 0);
        // exception overrides a parked jump
        step(1'b1, 2'd2, 32'h0,        32'h100,      0, 0, 32'h0000_0104, 2, 1, 0);
        step(1'b1, 2'd3, 32'h0,        32'h0,        0, 0, 32'h0000_0104, 2, 1, 1);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0104, 2, 1, 1);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0180, 3, 0, 0);
        // exception arriving on the same cycle imem becomes ready
        step(1'b1, 2'd1, 32'h200,      32'h0,        0, 0, 32'h0000_0184, 3, 1, 0);
        step(1'b1, 2'd3, 32'h0,        32'h0,        0, 1, 32'h0000_0184, 3, 1, 1);
        step(1'b1, 2'd0, 32'h0,        32'h0,        1, 1, 32'h0000_0180, 4, 0, 0);
        // branch in HOLD is ignored
        step(1'b1, 2'd2, 32'h0,        32'h300,      0, 0, 32'h0000_0180, 4, 1, 0);
        step(1'b1, 2'd1, 32'h500,      32'h0,        1, 1, 32'h0000_0180, 4, 1, 1);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0300, 5, 0, 0);
        // reset during HOLD drops the pending target
        step(1'b1, 2'd2, 32'h0,        32'h100,      0, 0, 32'h0000_0304, 5, 1, 0);
        step(1'b0, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0000_0304, 5, 0, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0000, 0, 0, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0004, 0, 0, 0);
        // wrap past the top of the address space
        step(1'b1, 2'd2, 32'h0,        32'hFFFF_FFFC, 0, 1, 32'h0000_0008, 0, 1, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'hFFFF_FFFC, 1, 0, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0000, 1, 0, 0);
        // misaligned branch target
        step(1'b1, 2'd1, 32'h43,       32'h0,        0, 1, 32'h0000_0004, 1, 1, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 0, 32'h0000_0040, 2, 0, 0);
        // back-to-back redirects drive the counter into saturation
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 2'd1, 32'h80, 32'h0, 0, 1,
                 (k == 0) ? 32'h40 : 32'h80,
                 ((2 + k) > 15) ? 4'd15 : 4'(2 + k), 1, 0);
        end
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0080, 15, 0, 0);
        step(1'b1, 2'd0, 32'h0,        32'h0,        0, 1, 32'h0000_0084, 15, 0, 0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
